cpu_core_param: RTL and testbench

Parametrised multi-cycle accumulator CPU core, the next generation of the 8-bit CPU top level: data width, address width and reset vector are parameters. It replaces free-running memory access with a single unified memory port that has a ready handshake, so ROM, RAM and wait-stated devices all sit behind an external decoder. It also adds a real halt state and a one-cycle instruction-retire strobe for the testbench monitor.

---
 rtl/cpu_core_param.sv | 163 ++++++++++++++++
 tb/tb_cpu_core_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Multi-cycle accumulator core with parameterised data and address widths.
// A single unified memory port with a ready handshake serves fetch, operand and data traffic.
module cpu_core_param #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halt,
  output logic              instr_done,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] x_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        flags_out
);

  typedef enum logic [2:0] {S_FETCH, S_OPERAND, S_MEM, S_EXEC, S_HALTED} state_t;

  localparam logic [3:0] OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3, OP_ADD = 4'h4,
                         OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8,
                         OP_TAX = 4'h9, OP_TXA = 4'hA, OP_INX = 4'hB, OP_JMP = 4'hC,
                         OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

  state_t            state, state_nxt;
  logic [3:0]        ir;
  logic [DATA_W-1:0] opnd, mdr, acc, x;
  logic [ADDR_W-1:0] pc, opnd_addr;
  logic [2:0]        flags;                 // {N,C,Z}

  logic [3:0]        fop;
  logic              fetch_has_opnd, ir_is_mem;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] acc_n, x_n;
  logic [2:0]        flags_n;
  logic              c_n, acc_wr, jump;

  assign opnd_addr      = ADDR_W'(opnd);
  assign fop            = mem_rdata[3:0];
  assign fetch_has_opnd = (fop >= OP_LDI && fop <= OP_XOR) || (fop >= OP_JMP && fop <= OP_JC);
  assign ir_is_mem      = (ir >= OP_LDA && ir <= OP_XOR);

  // FSM: next state and memory-port controls
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = pc;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = fetch_has_opnd ? S_OPERAND : S_EXEC;
      end
      S_OPERAND: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = ir_is_mem ? S_MEM : S_EXEC;
      end
      S_MEM: begin
        mem_addr = opnd_addr;
        if (ir == OP_STA) begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_done = 1'b1;
        state_nxt  = (ir == OP_HLT) ? S_HALTED : S_FETCH;
      end
      default: ;
    endcase
    // Requests must vanish the instant reset rises, before the async clear lands.
    if (reset) begin
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;

  assign sum  = {1'b0, acc} + {1'b0, mdr};
  assign diff = {1'b0, acc} - {1'b0, mdr};   // top bit is the unsigned borrow

  // EXEC register-update results
  always_comb begin
    acc_n  = acc;
    x_n    = x;
    c_n    = flags[1];
    acc_wr = 1'b0;
    jump   = 1'b0;
    case (ir)
      OP_LDI: begin acc_n = opnd;                 acc_wr = 1'b1; end
      OP_LDA: begin acc_n = mdr;                  acc_wr = 1'b1; end
      OP_ADD: begin acc_n = sum[DATA_W-1:0];      c_n = sum[DATA_W];  acc_wr = 1'b1; end
      OP_SUB: begin acc_n = diff[DATA_W-1:0];     c_n = diff[DATA_W]; acc_wr = 1'b1; end
      OP_AND: begin acc_n = acc & mdr;            c_n = 1'b0; acc_wr = 1'b1; end
      OP_OR:  begin acc_n = acc | mdr;            c_n = 1'b0; acc_wr = 1'b1; end
      OP_XOR: begin acc_n = acc ^ mdr;            c_n = 1'b0; acc_wr = 1'b1; end
      OP_TAX: x_n = acc;
      OP_TXA: begin acc_n = x;                    acc_wr = 1'b1; end
      OP_INX: x_n = x + DATA_W'(1);
      OP_JMP: jump = 1'b1;
      OP_JZ:  jump = flags[0];
      OP_JC:  jump = flags[1];
      default: ;
    endcase
    flags_n = acc_wr ? {acc_n[DATA_W-1], c_n, (acc_n == '0)} : flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      opnd  <= '0;
      mdr   <= '0;
      acc   <= '0;
      x     <= '0;
      flags <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= fop;
          pc <= pc + ADDR_W'(1);
        end
        S_OPERAND: if (mem_ready) begin
          opnd <= mem_rdata;
          pc   <= pc + ADDR_W'(1);
        end
        S_MEM: if (mem_ready && ir != OP_STA) mdr <= mem_rdata;
        S_EXEC: begin
          acc   <= acc_n;
          x     <= x_n;
          flags <= flags_n;
          if (jump) pc <= opnd_addr;
        end
        default: ;
      endcase
    end
  end

  assign mem_wdata = acc;
  assign halt      = (state == S_HALTED);
  assign acc_out   = acc;
  assign x_out     = x;
  assign pc_out    = pc;
  assign flags_out = flags;

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: small programs in a 256-byte memory,
// hand-computed register, flag, timing and bus-behaviour expectations.
module tb_cpu_core_param;

  logic clk = 1'b0;
  logic reset = 1'b1, reset_b = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] mem_addr, pc_out;
  logic        mem_rd, mem_wr, mem_ready, halt, instr_done;
  logic [7:0]  mem_wdata, mem_rdata, acc_out, x_out;
  logic [2:0]  flags_out;

  logic [7:0]  b_addr, b_pc, b_wdata, b_rdata, b_acc, b_x;
  logic        b_rd, b_wr, b_halt, b_done;
  logic [2:0]  b_flags;

  logic [7:0]  mem [256];
  logic        stall_all;
  int          wr_stall;

  cpu_core_param #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0010)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halt(halt),
    .instr_done(instr_done), .acc_out(acc_out), .x_out(x_out), .pc_out(pc_out),
    .flags_out(flags_out));

  cpu_core_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'hFF)) dut_b (
    .clk(clk), .reset(reset_b), .mem_addr(b_addr), .mem_rd(b_rd), .mem_wr(b_wr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(1'b1), .halt(b_halt),
    .instr_done(b_done), .acc_out(b_acc), .x_out(b_x), .pc_out(b_pc), .flags_out(b_flags));

  // Memory model: writes are recorded rather than stored; the first wr_stall write cycles wait.
  int          wr_seen, wr_count;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  assign mem_rdata = mem[mem_addr[7:0]];
  assign b_rdata   = mem[b_addr];
  assign mem_ready = !stall_all && !(mem_wr && wr_seen < wr_stall);

  always @(posedge clk or posedge reset)
    if (reset) begin
      wr_seen <= 0; wr_count <= 0; wr_addr <= '0; wr_data <= '0;
    end else if (mem_wr) begin
      wr_seen <= wr_seen + 1;
      if (mem_ready) begin
        wr_count <= wr_count + 1; wr_addr <= mem_addr; wr_data <= mem_wdata;
      end
    end

  // Cycle monitor: cycle 1 is the first cycle after reset release.
  int          cyc, ndone, wr_hi, wr_unstable;
  int          done_at [8];
  logic        prev_wr;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      cyc = 0; ndone = 0; wr_hi = 0; wr_unstable = 0; prev_wr = 1'b0;
    end else begin
      cyc++;
      if (instr_done && ndone < 8) begin done_at[ndone] = cyc; ndone++; end
      if (mem_wr) begin
        wr_hi++;
        if (prev_wr && (mem_addr != prev_addr || mem_wdata != prev_wdata)) wr_unstable++;
      end
      prev_wr = mem_wr; prev_addr = mem_addr; prev_wdata = mem_wdata;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d;
  endtask

  task automatic start();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #2;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n = 0;
    while (!halt && n < budget) begin step(1); n++; end
    chk({tag, "_halt"}, halt, 1);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    stall_all = 1'b0; wr_stall = 0;

    // LDI F0; ADD [80]; HLT with reset-state checks
    ld(8'h10, 8'h01); ld(8'h11, 8'hF0); ld(8'h12, 8'h04); ld(8'h13, 8'h80); ld(8'h14, 8'h0F);
    ld(8'h80, 8'h20);
    step(2);
    chk("rst_pc", pc_out, 16'h0010);
    chk("rst_outs", {acc_out, x_out, flags_out, halt, instr_done, mem_rd, mem_wr, mem_wdata}, 0);
    @(negedge clk); reset = 1'b0; #2;
    chk("first_rd", {mem_rd, mem_wr}, 2'b10);
    chk("first_addr", mem_addr, 16'h0010);
    run_to_halt("add", 40);
    chk("add_acc", acc_out, 8'h10);
    chk("add_flags", flags_out, 3'b010);
    chk("add_ndone", ndone, 3);
    chk("add_done0", done_at[0], 3);
    chk("add_done1", done_at[1], 7);
    chk("add_done2", done_at[2], 9);
    step(3);
    chk("halt_idle", {mem_rd, mem_wr, halt}, 3'b001);

    // LDI 05; SUB [81]; JZ 40 -- taken, then not taken
    ld(8'h10, 8'h01); ld(8'h11, 8'h05); ld(8'h12, 8'h05); ld(8'h13, 8'h81);
    ld(8'h14, 8'h0D); ld(8'h15, 8'h40); ld(8'h16, 8'h0F); ld(8'h40, 8'h0F);
    ld(8'h81, 8'h05);
    start();
    run_to_halt("subz", 40);
    chk("subz_acc", acc_out, 8'h00);
    chk("subz_flags", flags_out, 3'b001);
    chk("subz_pc", pc_out, 16'h0041);
    ld(8'h81, 8'h06);
    start();
    run_to_halt("subb", 40);
    chk("subb_acc", acc_out, 8'hFF);
    chk("subb_flags", flags_out, 3'b110);
    chk("subb_pc", pc_out, 16'h0017);

    // LDI 77; STA 90 with three wait cycles; HLT
    ld(8'h10, 8'h01); ld(8'h11, 8'h77); ld(8'h12, 8'h03); ld(8'h13, 8'h90); ld(8'h14, 8'h0F);
    wr_stall = 3;
    start();
    run_to_halt("sta", 40);
    wr_stall = 0;
    chk("sta_count", wr_count, 1);
    chk("sta_addr", wr_addr, 16'h0090);
    chk("sta_data", wr_data, 8'h77);
    chk("sta_wr_cycles", wr_hi, 4);
    chk("sta_stable", wr_unstable, 0);
    chk("sta_done", done_at[1], 9);
    chk("sta_latency", done_at[1] - done_at[0], 6);

    // LDI FF; TAX; INX; HLT -- X wraps, flags untouched
    ld(8'h10, 8'h01); ld(8'h11, 8'hFF); ld(8'h12, 8'h09); ld(8'h13, 8'h0B); ld(8'h14, 8'h0F);
    start();
    run_to_halt("inx", 40);
    chk("inx_x", x_out, 8'h00);
    chk("inx_acc", acc_out, 8'hFF);
    chk("inx_flags", flags_out, 3'b100);
    chk("inx_done", done_at[2], 7);

    // AND/OR/XOR, JMP, LDA, ADD with carry, JC taken
    ld(8'h10, 8'h01); ld(8'h11, 8'h3C); ld(8'h12, 8'h06); ld(8'h13, 8'h83);
    ld(8'h14, 8'h07); ld(8'h15, 8'h84); ld(8'h16, 8'h08); ld(8'h17, 8'h85);
    ld(8'h18, 8'h0C); ld(8'h19, 8'h50);
    ld(8'h50, 8'h02); ld(8'h51, 8'h86); ld(8'h52, 8'h04); ld(8'h53, 8'h86);
    ld(8'h54, 8'h0E); ld(8'h55, 8'h60); ld(8'h60, 8'h0F);
    ld(8'h83, 8'h0F); ld(8'h84, 8'h50); ld(8'h85, 8'h5C); ld(8'h86, 8'h80);
    start();
    run_to_halt("alu", 80);
    chk("alu_acc", acc_out, 8'h00);
    chk("alu_flags", flags_out, 3'b011);
    chk("alu_pc", pc_out, 16'h0061);

    // Reset during a stalled LDA read
    ld(8'h10, 8'h01); ld(8'h11, 8'h33); ld(8'h12, 8'h02); ld(8'h13, 8'h82); ld(8'h14, 8'h0F);
    ld(8'h82, 8'h5A);
    start();
    step(5);
    stall_all = 1'b1;
    step(2);
    chk("stall_req", {mem_rd, mem_wr}, 2'b10);
    chk("stall_addr", mem_addr, 16'h0082);
    chk("stall_acc", acc_out, 8'h33);
    reset = 1'b1;
    #1;
    chk("abort_rd", mem_rd, 0);
    step(1);
    stall_all = 1'b0;
    @(negedge clk); reset = 1'b0; #2;
    chk("abort_acc", acc_out, 8'h00);
    chk("abort_refetch", {mem_rd, mem_addr}, {1'b1, 16'h0010});

    // 8-bit address space: NOP at FF, next fetch wraps to 00
    @(negedge clk); reset_b = 1'b0; #2;
    chk("wrap_first", {b_rd, b_addr}, {1'b1, 8'hFF});
    step(2);
    chk("wrap_addr", {b_rd, b_addr}, {1'b1, 8'h00});
    chk("wrap_pc", b_pc, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
